regfile_dump_ctrl: RTL and testbench

Debug-side controller that sequences a full dump of the ID-stage register file over read port 1. While the pipeline is halted, it takes ownership of the read port and walks the register addresses 0..SIZE_REG-1. Each register word is captured and streamed out on a valid/ready handshake toward the debug UART TX path. Nothing is dumped unless the pipeline is halted; the register file write port is never touched.

---
 rtl/regfile_dump_ctrl_if.sv | 14 +
 rtl/regfile_dump_ctrl.sv | 96 +++++++++
 tb/tb_regfile_dump_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_ctrl_if.sv
// regfile_dump_ctrl_if: valid/ready word stream from the register dump controller to the debug TX path.
//   tx_data  : dumped register word (driven by master)
//   tx_valid : tx_data holds a word (driven by master)
//   tx_ready : downstream accepts the word when valid & ready (driven by slave)
interface regfile_dump_ctrl_if #(
    parameter int NB_DATA = 32
);
    logic [NB_DATA-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: walks register file read port 1 while the pipeline is halted and streams every word out.
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_start                : dump request, honoured only when idle
//   i_pipe_halted          : reads happen only while this is high
//   o_rf_sel, o_rf_address : read port 1 ownership and address
//   i_rf_data              : combinational read data of port 1
//   tx                     : valid/ready word stream (master side)
//   o_busy, o_done         : activity flag, one-cycle completion pulse
module regfile_dump_ctrl #(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int SIZE_REG = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_pipe_halted,
    output logic                 o_rf_sel,
    output logic [NB_REG-1:0]    o_rf_address,
    input  logic [NB_DATA-1:0]   i_rf_data,
    regfile_dump_ctrl_if.master  tx,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam logic [NB_REG-1:0] LAST = NB_REG'(SIZE_REG - 1);

    typedef enum logic [2:0] {IDLE, WAIT_HALT, READ, SEND, DONE} state_t;

    state_t            state;
    logic [NB_REG-1:0] idx;

    // Outputs are registered and set for the state being entered, so each
    // one lines up with the state it belongs to without any combinational path.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            idx          <= '0;
            tx.tx_data   <= '0;
            tx.tx_valid  <= 1'b0;
            o_rf_sel     <= 1'b0;
            o_rf_address <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    idx    <= '0;
                    o_busy <= 1'b1;
                    if (i_pipe_halted) begin
                        state        <= READ;
                        o_rf_sel     <= 1'b1;
                        o_rf_address <= '0;
                    end else begin
                        state <= WAIT_HALT;
                    end
                end
                WAIT_HALT: if (i_pipe_halted) begin
                    state        <= READ;
                    o_rf_sel     <= 1'b1;
                    o_rf_address <= idx;
                end
                READ: begin
                    o_rf_sel <= 1'b0;
                    // Halt lost mid-read: drop the read and retry the same index later.
                    if (i_pipe_halted) begin
                        tx.tx_data  <= i_rf_data;
                        tx.tx_valid <= 1'b1;
                        state       <= SEND;
                    end else begin
                        state <= WAIT_HALT;
                    end
                end
                SEND: if (tx.tx_ready) begin
                    tx.tx_valid <= 1'b0;
                    // Terminal compare first so the index never wraps.
                    if (idx == LAST) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        idx          <= idx + 1'b1;
                        state        <= READ;
                        o_rf_sel     <= 1'b1;
                        o_rf_address <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    o_busy       <= 1'b0;
                    o_rf_address <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: table-driven and scoreboard checks of the register dump controller.
module tb_regfile_dump_ctrl;
    localparam int NB_DATA  = 32;
    localparam int NB_REG   = 5;
    localparam int SIZE_REG = 32;

    typedef struct {
        logic rst, start, halted, ready;
        logic busy, sel, valid, done;
        logic [NB_REG-1:0] addr;
    } vec_t;

    typedef struct {
        logic [NB_DATA-1:0] data;
        int                 cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic halted = 1'b0;
    logic rf_sel, busy, done;
    logic [NB_REG-1:0]  rf_addr;
    logic [NB_DATA-1:0] rf_data;
    logic [NB_DATA-1:0] rf [SIZE_REG];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   words = 0;
    exp_t sb[$];
    exp_t e;
    logic stall = 1'b0;
    logic [NB_DATA-1:0] stall_data = '0;
    vec_t tbl [10];

    regfile_dump_ctrl_if #(.NB_DATA(NB_DATA)) tx ();

    regfile_dump_ctrl #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .SIZE_REG(SIZE_REG)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_pipe_halted(halted),
        .o_rf_sel     (rf_sel),
        .o_rf_address (rf_addr),
        .i_rf_data    (rf_data),
        .tx           (tx),
        .o_busy       (busy),
        .o_done       (done)
    );

    assign rf_data = rf[rf_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    // base < 0 means acceptance cycles are not checked.
    task automatic push_all(input int base, input int delay_from3);
        for (int k = 0; k < SIZE_REG; k++) begin
            exp_t x;
            x.data = 32'hA500_0000 + k;
            x.cyc  = (base < 0) ? -1 : base + 2 + 2 * k + ((k >= 3) ? delay_from3 : 0);
            sb.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx.tx_valid && tx.tx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none at cycle %0d", tx.tx_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("word_data", tx.tx_data, e.data);
                    if (e.cyc >= 0) chk("word_cycle", cyc, e.cyc);
                end
                words++;
            end
            if (stall) begin
                chk("stall_data_stable", tx.tx_data, stall_data);
                chk("stall_valid_held", tx.tx_valid, 1'b1);
            end
            if (rf_sel) chk("rf_sel_outside_read", tx.tx_valid | !busy, 1'b0);
            stall      = tx.tx_valid && !tx.tx_ready;
            stall_data = tx.tx_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall = 1'b0;
        end
    end

    initial begin
        int c0, d0, w0;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
        tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        for (int i = 0; i < SIZE_REG; i++) rf[i] = 32'hA500_0000 + i;
        tx.tx_ready = 1'b0;

        // Short cycle-by-cycle walk: reset, halt wait, backpressure, halt loss, abort.
        begin
            exp_t x;
            x.data = 32'hA500_0000;
            x.cyc  = -1;
            sb.push_back(x);
        end
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; halted = tbl[i].halted; tx.tx_ready = tbl[i].ready;
            tick();
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_sel", i), rf_sel, tbl[i].sel);
            chk($sformatf("tbl%0d_valid", i), tx.tx_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            chk($sformatf("tbl%0d_addr", i), rf_addr, tbl[i].addr);
        end
        chk("tbl_queue_empty", sb.size(), 0);

        // Full dump, halted and ready held high.
        rst = 1'b0; start = 1'b0; halted = 1'b1; tx.tx_ready = 1'b1;
        tick();
        c0 = cyc; d0 = done_cnt; w0 = words;
        push_all(c0, 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_idle(200);
        chk("full_idle_cycle", cyc, c0 + 66);
        chk("full_done_count", done_cnt - d0, 1);
        chk("full_done_cycle", done_cyc, c0 + 65);
        chk("full_words", words - w0, SIZE_REG);
        chk("full_last_word_held", tx.tx_data, 32'hA500_001F);

        // Backpressure: ready low five cycles while word 3 is offered.
        c0 = cyc; d0 = done_cnt;
        push_all(c0, 5);
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        chk("bp_word3_valid", tx.tx_valid, 1'b1);
        chk("bp_word3_data", tx.tx_data, 32'hA500_0003);
        tx.tx_ready = 1'b0;
        repeat (5) tick();
        tx.tx_ready = 1'b1;
        wait_idle(200);
        chk("bp_done_count", done_cnt - d0, 1);
        chk("bp_done_cycle", done_cyc, c0 + 70);
        chk("bp_queue_empty", sb.size(), 0);

        // Start while not halted: wait ten cycles, then release.
        halted = 1'b0;
        c0 = cyc; d0 = done_cnt;
        push_all(c0 + 11, 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("wh_busy", busy, 1'b1);
            chk("wh_sel", rf_sel, 1'b0);
            chk("wh_valid", tx.tx_valid, 1'b0);
            tick();
        end
        halted = 1'b1;
        tick();
        chk("wh_read_sel", rf_sel, 1'b1);
        chk("wh_read_addr", rf_addr, 5'd0);
        wait_idle(200);
        chk("wh_done_count", done_cnt - d0, 1);
        chk("wh_done_cycle", done_cyc, c0 + 11 + 65);

        // Halt drops while reading reg 7; reg 7 rewritten before the retry.
        c0 = cyc; d0 = done_cnt; w0 = words;
        for (int k = 0; k < SIZE_REG; k++) begin
            exp_t x;
            x.data = (k == 7) ? 32'hDEAD_BEEF : 32'hA500_0000 + k;
            x.cyc  = -1;
            sb.push_back(x);
        end
        start = 1'b1; tick(); start = 1'b0;
        repeat (14) tick();
        chk("hd_read7_addr", rf_addr, 5'd7);
        halted = 1'b0;
        rf[7] = 32'hDEAD_BEEF;
        tick();
        chk("hd_wait_busy", busy, 1'b1);
        chk("hd_wait_sel", rf_sel, 1'b0);
        chk("hd_wait_valid", tx.tx_valid, 1'b0);
        tick(); tick();
        halted = 1'b1;
        tick();
        chk("hd_retry_sel", rf_sel, 1'b1);
        chk("hd_retry_addr", rf_addr, 5'd7);
        wait_idle(200);
        chk("hd_words", words - w0, SIZE_REG);
        chk("hd_done_count", done_cnt - d0, 1);
        chk("hd_queue_empty", sb.size(), 0);
        rf[7] = 32'hA500_0007;

        // Reset while word 12 is offered.
        c0 = cyc;
        push_all(c0, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (25) tick();
        chk("rs_word12_valid", tx.tx_valid, 1'b1);
        chk("rs_word12_data", tx.tx_data, 32'hA500_000C);
        rst = 1'b1; tx.tx_ready = 1'b0;
        tick();
        rst = 1'b0; tx.tx_ready = 1'b1;
        chk("rs_busy", busy, 1'b0);
        chk("rs_sel", rf_sel, 1'b0);
        chk("rs_addr", rf_addr, 5'd0);
        chk("rs_valid", tx.tx_valid, 1'b0);
        chk("rs_data", tx.tx_data, 32'h0);
        chk("rs_done", done, 1'b0);
        sb.delete();
        d0 = done_cnt;
        repeat (3) tick();
        chk("rs_no_done", done_cnt - d0, 0);
        chk("rs_still_idle", busy, 1'b0);
        c0 = cyc;
        push_all(c0, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("rs_restart_sel", rf_sel, 1'b1);
        chk("rs_restart_addr", rf_addr, 5'd0);
        wait_idle(200);
        chk("rs_restart_done", done_cnt - d0, 1);

        // Start re-pulsed mid-dump and held through DONE: all ignored.
        c0 = cyc; d0 = done_cnt;
        push_all(c0, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (19) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (43) tick();
        start = 1'b1;
        tick();
        chk("rp_done_pulse", done, 1'b1);
        tick();
        chk("rp_idle_after_done", busy, 1'b0);
        start = 1'b0;
        repeat (3) tick();
        chk("rp_stays_idle", busy, 1'b0);
        chk("rp_done_count", done_cnt - d0, 1);
        chk("rp_done_cycle", done_cyc, c0 + 65);
        chk("rp_queue_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
